// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM state
// encoding and the signed-overflow helper used by the add/subtract path.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Overflow when both addend signs agree but the sum's sign differs.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add multiplier core: holds the 2*WIDTH accumulator, the multiplicand,
// the shifting multiplier and the step counter. One step per cycle on step=1.
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod_next,
    output logic               last
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] step_acc_s;

    // Accumulator value after one step: add into the upper half, shift right.
    always_comb begin
        if (mplier_q[0]) begin
            addend_s = mcand_q;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        sum_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
        step_acc_s = {sum_s, acc_q[WIDTH-1:1]};
    end

    // Next-state selection for load, step or hold.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = {(2*WIDTH){1'b0}};
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = CNT_W'(WIDTH - 1);
        end else if (step) begin
            acc_d    = step_acc_s;
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            acc_d    = acc_q;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign prod_next = step_acc_s;
    assign last      = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with single-cycle logic/arithmetic ops and a multi-cycle
// shift-add multiply behind a start/busy/done handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    state_e state_q, state_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             accept_s;
    logic             mul_load_s;
    logic             mul_step_s;
    logic             mul_last_s;
    logic [2*WIDTH-1:0] mul_prod_s;

    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic             ovf_add_s;
    logic             ovf_sub_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_cout_s;
    logic             alu_ovf_s;
    logic             alu_ill_s;

    assign accept_s   = start && (state_q == ST_IDLE);
    assign mul_load_s = accept_s && (op == OP_MUL);
    assign mul_step_s = (state_q == ST_MUL);

    mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (mul_load_s),
        .step      (mul_step_s),
        .a         (a),
        .b         (b),
        .prod_next (mul_prod_s),
        .last      (mul_last_s)
    );

    // Single-cycle datapath; SUB uses a + ~b + 1 so cout=1 means no borrow.
    always_comb begin
        add_s      = {1'b0, a} + {1'b0, b};
        sub_s      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        ovf_add_s  = add_ovf(a[MSB], b[MSB], add_s[MSB]);
        ovf_sub_s  = add_ovf(a[MSB], ~b[MSB], sub_s[MSB]);
        alu_res_s  = {WIDTH{1'b0}};
        alu_cout_s = 1'b0;
        alu_ovf_s  = 1'b0;
        alu_ill_s  = 1'b0;
        case (op)
            OP_AND: alu_res_s = a & b;
            OP_OR:  alu_res_s = a | b;
            OP_ADD: begin
                alu_res_s  = add_s[WIDTH-1:0];
                alu_cout_s = add_s[WIDTH];
                alu_ovf_s  = ovf_add_s;
            end
            OP_SUB: begin
                alu_res_s  = sub_s[WIDTH-1:0];
                alu_cout_s = sub_s[WIDTH];
                alu_ovf_s  = ovf_sub_s;
            end
            OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, sub_s[MSB] ^ ovf_sub_s};
            OP_MUL: alu_res_s = {WIDTH{1'b0}};
            default: alu_ill_s = 1'b1;
        endcase
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mul_load_s) begin
                    state_d = ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register next values; everything but done holds between ops.
    always_comb begin
        result_d    = result_q;
        result_hi_d = result_hi_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        done_d      = 1'b0;
        busy_d      = (state_d == ST_MUL);
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (op != OP_MUL)) begin
                    result_d    = alu_res_s;
                    result_hi_d = {WIDTH{1'b0}};
                    cout_d      = alu_cout_s;
                    ovf_d       = alu_ovf_s;
                    zero_d      = (alu_res_s == {WIDTH{1'b0}});
                    illegal_d   = alu_ill_s;
                    done_d      = 1'b1;
                end else begin
                    done_d      = 1'b0;
                end
            end
            ST_MUL: begin
                if (mul_last_s) begin
                    result_d    = mul_prod_s[WIDTH-1:0];
                    result_hi_d = mul_prod_s[2*WIDTH-1:WIDTH];
                    cout_d      = 1'b0;
                    ovf_d       = 1'b0;
                    zero_d      = (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    illegal_d   = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    done_d      = 1'b0;
                end
            end
            default: done_d = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= {WIDTH{1'b0}};
            result_hi_q <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written multiply/reset sequences.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf, zero, illegal;
    logic [W-1:0] result, result_hi;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        ill;
    } vec_t;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Reference model from the arithmetic definition of each operation.
    function automatic exp_t model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] p;
        longint      maxv;
        longint      minv;
        maxv = 64'sh7FFFFFFF;
        minv = -64'sh80000000;
        sa = $signed(ma);
        sb = $signed(mb);
        e  = '{res: 32'd0, hi: 32'd0, cout: 1'b0, ovf: 1'b0, zero: 1'b0, ill: 1'b0};
        case (mop)
            3'b000: e.res = ma & mb;
            3'b001: e.res = ma | mb;
            3'b010: begin
                p = {32'd0, ma} + {32'd0, mb};
                e.res = p[31:0];
                e.cout = p[32];
                s = sa + sb;
                e.ovf = (s > maxv) || (s < minv);
            end
            3'b110: begin
                e.res = ma - mb;
                e.cout = (ma >= mb);
                s = sa - sb;
                e.ovf = (s > maxv) || (s < minv);
            end
            3'b111: e.res = (sa < sb) ? 32'd1 : 32'd0;
            3'b011: begin
                p = {32'd0, ma} * {32'd0, mb};
                e.res = p[31:0];
                e.hi  = p[63:32];
            end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic chk_outs(input string tag, input exp_t e);
        chk({tag, " result"},    result,    e.res);
        chk({tag, " result_hi"}, result_hi, e.hi);
        chk({tag, " cout"},      cout,      e.cout);
        chk({tag, " ovf"},       ovf,       e.ovf);
        chk({tag, " zero"},      zero,      e.zero);
        chk({tag, " illegal"},   illegal,   e.ill);
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the sampling edge.
    task automatic issue(input logic [2:0] iop, input logic [31:0] ia, input logic [31:0] ib);
        start = 1'b1;
        op    = iop;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_mul(input logic [31:0] ma, input logic [31:0] mb, input bit poke, output int lat);
        bit busy_bad;
        busy_bad = 1'b0;
        lat = 0;
        issue(3'b011, ma, mb);
        chk("mul busy after start", busy, 1'b1);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busy_bad = 1'b1;
            if (poke && n == 5) begin
                start = 1'b1;
                op    = 3'b010;
                a     = 32'd1;
                b     = 32'd1;
            end else if (poke && n == 6) begin
                start = 1'b0;
            end
        end
        if (lat == 0) lat = 99;
        chk("mul latency", lat, 32);
        chk("mul busy held low-free", busy_bad, 1'b0);
        chk("mul busy at done", busy, 1'b0);
    endtask

    vec_t tbl [12];
    logic [2:0] rop [7];
    int   lat;
    bit   seen_done;
    exp_t e;

    initial begin
        tbl[0]  = '{3'b000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{3'b001, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'b010, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'b110, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h4B4B4B4B, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'b100, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{3'b000, 32'h000000FF, 32'h0000000F, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{3'b101, 32'h0000000A, 32'h0000000B, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        rop = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk_outs("reset", '{res: 32'd0, hi: 32'd0, cout: 1'b0, ovf: 1'b0, zero: 1'b0, ill: 1'b0});
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            chk($sformatf("vec%0d done", i), done, 1'b1);
            chk($sformatf("vec%0d busy", i), busy, 1'b0);
            chk_outs($sformatf("vec%0d", i), '{res: tbl[i].res, hi: 32'd0, cout: tbl[i].cout,
                                              ovf: tbl[i].ovf, zero: tbl[i].zero, ill: tbl[i].ill});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d done cleared", i), done, 1'b0);
            chk($sformatf("vec%0d result held", i), result, tbl[i].res);
        end

        // Back-to-back random single-cycle ops, one per clock.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rp;
            logic [31:0] ra;
            logic [31:0] rb;
            rp = rop[$urandom_range(0, 6)];
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            issue(rp, ra, rb);
            chk($sformatf("rnd%0d done", i), done, 1'b1);
            chk_outs($sformatf("rnd%0d op%0d", i, rp), model(rp, ra, rb));
        end
        @(posedge clk);
        #1;

        run_mul(32'h00010000, 32'h00010000, 1'b1, lat);
        chk_outs("mul 10000sq", model(3'b011, 32'h00010000, 32'h00010000));
        @(posedge clk);
        #1;
        chk("mul no extra done", done, 1'b0);
        chk("mul idle busy", busy, 1'b0);

        for (int i = 0; i < 3; i++) begin
            logic [31:0] ma;
            logic [31:0] mb;
            ma = $urandom;
            mb = $urandom;
            run_mul(ma, mb, 1'b0, lat);
            chk_outs($sformatf("mul rnd%0d", i), model(3'b011, ma, mb));
        end

        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat);
        chk_outs("mul ffff", model(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF));
        chk("mul ffff hi", result_hi, 32'hFFFFFFFE);
        // Start raised on the done cycle must be accepted.
        issue(3'b010, 32'd10, 32'd20);
        chk("b2b done", done, 1'b1);
        chk("b2b result", result, 32'd30);
        chk("b2b result_hi", result_hi, 32'd0);

        issue(3'b011, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort result", result, 32'd0);
        chk("abort result_hi", result_hi, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        chk("abort no done", seen_done, 1'b0);
        issue(3'b010, 32'd2, 32'd3);
        e = model(3'b010, 32'd2, 32'd3);
        chk("post-reset add done", done, 1'b1);
        chk_outs("post-reset add", e);
        chk("post-reset add value", result, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the combinational 32-bit ALU. It adds subtract, set-less-than, status flags and a multi-cycle unsigned shift-add multiply behind a start/busy/done handshake. It sits between the register-file read stage and writeback in the lab datapath, so the controller can issue single-cycle logic/arithmetic ops and stall on multiply.

## Interface
- WIDTH, 32: operand/result width in bits, ≥4.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- start  in  1  request; sampled only when busy=0.
- op  in  3  operation code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MUL; 100/101 illegal.
- a, b  in  WIDTH  operands; sampled with start.
- busy  out  1  high while a MUL is in progress.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle on.
- result  out  WIDTH  result, or MUL low half.
- result_hi  out  WIDTH  MUL high half; 0 for all other ops.
- cout  out  1  carry out of ADD/SUB; 0 otherwise.
- ovf  out  1  signed overflow of ADD/SUB; 0 otherwise.
- zero  out  1  result==0 (result_hi ignored).
- illegal  out  1  set with done for op 100/101.

## Operation
- FSM states are IDLE and MUL. Reset puts the FSM in IDLE with every output at 0.
- IDLE with start=1 and a non-MUL op:
  - compute and register all outputs at that edge, pulse done, stay in IDLE.
- ADD: {cout,result} = a+b.
- SUB: {cout,result} = a+~b+1, so cout=1 means no borrow.
- ovf = (sign a == sign of the effective b operand) && (sign result != sign a).
- SLT: result = {0…, (a−b)[MSB] XOR ovf_sub}, a signed compare. cout=0, ovf=0.
- AND/OR: result = a&b or a|b.
- Illegal op: result=0, illegal=1, done pulse.
- IDLE with start=1 and op=MUL:
  - latch a and b, clear the accumulator, load the step counter with WIDTH−1, go to MUL, busy=1.
- MUL state, one step per cycle:
  - if multiplier LSB=1, add the multiplicand into the upper half of the 2·WIDTH accumulator (with carry), then shift the accumulator right by 1.
  - When the counter is 0 at the edge, take the final step, write {result_hi,result}, pulse done, set busy=0 and return to IDLE. Otherwise decrement the counter.
- start while busy=1 is ignored; no queueing.
- Between operations, result, flags and illegal hold their last values. Only done is cleared, the cycle after its pulse.
- Back-to-back operation is allowed: start in the same cycle as done is accepted.
- Asserting rst_n low during MUL aborts it immediately. busy, done and all outputs go to 0, and no done pulse follows.

## Timing
- Non-MUL ops: start sampled at edge E0; done=1 and results visible in the cycle after E0. Latency is 1 cycle; throughput is 1 op per cycle.
- MUL: start at E0; busy=1 after E0 through EWIDTH−1. After EWIDTH, done=1 and busy=0. Latency is WIDTH cycles.
- busy and done are never high together.
- Outputs are driven by registers only; there is no combinational path from inputs to outputs.
- Reset assertion takes effect without a clock edge. Deassertion is synchronised externally.

## Structure
- Shared package alu_pkg:
  - op-code localparams OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MUL;
  - state encoding ST_IDLE, ST_MUL.
- Sub-module mul_shift_add holds the accumulator, the multiplicand register and the step counter; WIDTH is parametrised. It has load/step inputs and a last output. seq_alu owns the FSM, the single-cycle datapath and the output registers.

## Test plan
- WIDTH=32, a=A5A5A5A5, b=5A5A5A5A:
  - AND → result=0, zero=1.
  - OR → FFFFFFFF.
  - ADD → FFFFFFFF, cout=0.
  - Each case: done exactly 1 cycle after start, busy never high.
- SUB with the same operands → result=4B4B4B4B, cout=1, ovf=1. ADD 7FFFFFFF+1 → 80000000, ovf=1.
- SLT:
  - a=FFFFFFFF, b=1 → result=1.
  - a=1, b=FFFFFFFF → 0.
  - a=80000000, b=7FFFFFFF → 1.
- MUL 00010000×00010000 → result=0, result_hi=1, zero=1, done exactly 32 cycles after start. A start pulsed at cycle 5 of the MUL is ignored. FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- Reset mid-operation: rst_n low 10 cycles into a MUL → busy=0 and result=0 immediately, and no done pulse follows. A new ADD 2+3 after reset → 5.
- Illegal op 100 → illegal=1, result=0, done pulse. A following legal op clears illegal. Back-to-back start on the done cycle is accepted.
